// File: rtl/counter_sequencer.sv
// counter_sequencer: drives an up/down counter's control pins through a
// programmed lo -> hi -> lo triangle sweep, one step every presc+1 cycles,
// for a programmed number of passes (0 = until stopped).
module counter_sequencer #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8,
    parameter int PASS_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic [PASS_W-1:0]  cfg_passes,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   cnt_value,
    output logic               cnt_enable,
    output logic               cnt_load,
    output logic               cnt_up_down,
    output logic [WIDTH-1:0]   cnt_load_val,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PASS_W-1:0]  pass_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PASS_W-1:0]  passes_q;

    logic               in_range;
    logic               at_hi;
    logic               at_lo;
    logic               tick;
    logic [PASS_W-1:0]  pass_next;

    assign in_range  = (cnt_value >= lo_q) && (cnt_value <= hi_q);
    assign at_hi     = (cnt_value == hi_q);
    assign at_lo     = (cnt_value == lo_q);
    assign tick      = (presc_cnt == presc_q);
    assign pass_next = pass_cnt + 1'b1;

    // Step strobe: the load pulse, or a paced step that is withheld whenever
    // the counter already sits on the target bound (or is out of range).
    always_comb begin
        cnt_enable = 1'b0;
        case (state)
            LOAD:    cnt_enable = 1'b1;
            UP:      cnt_enable = in_range && !at_hi && tick;
            DOWN:    cnt_enable = in_range && !at_lo && tick;
            default: cnt_enable = 1'b0;
        endcase
    end

    // Sequencer FSM; the status/control outputs are registered and always
    // describe the state being entered on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            presc_q      <= '0;
            passes_q     <= '0;
            presc_cnt    <= '0;
            pass_cnt     <= '0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            cnt_up_down  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            cnt_up_down  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (cfg_lo >= cfg_hi) begin
                            err <= 1'b1;
                        end else begin
                            lo_q         <= cfg_lo;
                            hi_q         <= cfg_hi;
                            presc_q      <= cfg_presc;
                            passes_q     <= cfg_passes;
                            pass_cnt     <= '0;
                            state        <= LOAD;
                            cnt_load     <= 1'b1;
                            cnt_load_val <= cfg_lo;
                            cnt_up_down  <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (stop) begin
                        state <= IDLE;
                    end else begin
                        state       <= UP;
                        presc_cnt   <= '0;
                        cnt_up_down <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                UP: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (!in_range) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (at_hi) begin
                        presc_cnt <= '0;
                        state     <= DOWN;
                        busy      <= 1'b1;
                    end else begin
                        presc_cnt   <= tick ? '0 : presc_cnt + 1'b1;
                        cnt_up_down <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                DOWN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (!in_range) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (at_lo) begin
                        pass_cnt  <= pass_next;
                        presc_cnt <= '0;
                        if ((passes_q != '0) && (pass_next == passes_q)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= UP;
                            cnt_up_down <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end else begin
                        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                        busy      <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Sequencer that drives the programmable up/down counter's control pins (enable, load, direction, load value) to run a programmed triangle sweep between a low and a high bound. It sits between the top-level configuration inputs and the counter instance, closing the loop on the counter's registered output. It paces count steps with a prescaler and repeats a programmed number of full passes, or runs until stopped. It reports busy, done and error status.

## Interface

- WIDTH, 8, counter / bound width
- PRESC_W, 8, prescaler width
- PASS_W, 4, pass count width
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- cfg_lo  input  WIDTH  sweep low bound; sampled on accepted start
- cfg_hi  input  WIDTH  sweep high bound; sampled on accepted start
- cfg_presc  input  PRESC_W  one step every cfg_presc+1 cycles; sampled on accepted start
- cfg_passes  input  PASS_W  full passes (lo→hi→lo) to run; 0 = run until stop
- start  input  1  request; honoured only in IDLE
- stop  input  1  abort; priority over everything except rst
- cnt_value  input  WIDTH  counter's registered output
- cnt_enable  output  1  counter enable (step or load strobe)
- cnt_load  output  1  counter load strobe
- cnt_up_down  output  1  direction; 1 = up
- cnt_load_val  output  WIDTH  value to load
- busy  output  1  high in LOAD/UP/DOWN
- done  output  1  one-cycle pulse on normal completion
- err  output  1  one-cycle pulse on bad config or range violation
- pass_cnt  output  PASS_W  completed passes in current/last run

## Operation

- Counter contract: counter updates on the clk edge where cnt_enable is high; with cnt_load high it loads cnt_load_val, else steps ±1 per cnt_up_down. cnt_value reflects that edge in the next cycle.
- States: IDLE, LOAD, UP, DOWN, DONE. Reset → IDLE; all outputs 0, pass_cnt 0, shadow config 0, prescaler 0.
- IDLE: outputs 0 except pass_cnt (holds). On start with cfg_lo >= cfg_hi: err pulse next cycle, remain IDLE, pass_cnt held. On start with cfg_lo < cfg_hi: latch cfg_* into shadow registers, clear pass_cnt, → LOAD.
- LOAD (1 cycle): cnt_enable=1, cnt_load=1, cnt_load_val=lo_q, cnt_up_down=1. → UP, prescaler cleared.
- UP: cnt_up_down=1. If cnt_value == hi_q: no step, prescaler cleared, → DOWN. Otherwise, when prescaler == presc_q: cnt_enable=1 and prescaler cleared; else prescaler increments.
- DOWN: cnt_up_down=0, same pacing. If cnt_value == lo_q: pass complete, no step, pass_cnt+1, prescaler cleared. Then → DONE if passes_q != 0 and new pass_cnt == passes_q, else → UP.
- pass_cnt wraps modulo 2^PASS_W when passes_q == 0.
- Range check in UP/DOWN: cnt_value < lo_q or > hi_q → err pulse, → IDLE (no done).
- DONE (1 cycle): done=1, busy=0 → IDLE.
- stop in any non-IDLE state → IDLE next cycle; no done, no err; pass_cnt holds. stop and start in the same IDLE cycle: start ignored.
- start while not IDLE is ignored. cfg_* changes mid-run have no effect.
- rst mid-run: IDLE next cycle, all outputs 0 in that cycle.

## Timing

- busy, done, err, cnt_load, cnt_load_val, cnt_up_down: decoded from registered state only.
- cnt_enable in UP/DOWN: combinational on cnt_value compare (Mealy); no step is ever issued in a cycle where cnt_value equals the target bound, so the counter never overshoots.
- Start accepted in cycle 0 → LOAD in cycle 1 → UP in cycle 2 with cnt_value = lo. First step is in cycle 2+presc.
- Each bound turnaround costs one non-step cycle. Period per pass with presc=0 is 2·(hi−lo)+2 cycles.
- err and done pulses last exactly 1 cycle.

## Test plan

- lo=3, hi=6, presc=0, passes=1, start@0 → cnt_load@1; cnt_enable@2,3,4 (up); cnt_value=6@5; cnt_enable@6,7,8 (down); cnt_value=3@9; done@10, pass_cnt=1, busy low @10.
- lo=0, hi=2, presc=2, passes=2 → steps spaced 3 cycles apart; two full triangles; done once; pass_cnt=2.
- lo=5, hi=5, start → err pulse 1 cycle, busy never high, no cnt_load.
- passes=0, lo=1, hi=2, run 40 passes → pass_cnt wraps 15→0; stop mid-UP → busy low next cycle, no done, cnt_enable 0.
- Force cnt_value=hi+1 in UP → err pulse, return to IDLE; start pulses while busy are ignored (config unchanged).
- rst asserted in DOWN → all outputs 0 next cycle; a new start afterwards runs normally.
